// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control slice.
//   - sw_state_e : 2-bit FSM state encoding (IDLE=0, RUN=1, PAUSE=2, LAP=3),
//                  also driven out on the state port for LEDs/debug.
//   - CLK_HZ     : default system clock rate; one count tick per second.
//   - ctr_width  : bit width of a counter that must hold 0..n-1
//                  (clog2(n), never below 1).
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } sw_state_e;

    localparam int CLK_HZ = 50_000_000;

    function automatic int ctr_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_button.sv
// button_conditioner: turns one raw, active-low, asynchronous pushbutton
// into a single-cycle press pulse.
//   clk, rst_n : system clock, asynchronous active-low reset
//   key_n      : raw button level (0 = pressed), asynchronous to clk
//   press      : one-cycle pulse on an accepted released->pressed change
// A 2-flop synchronizer feeds a stability counter; a new level is accepted
// only after DEBOUNCE_CYCLES consecutive cycles that differ from the
// current accepted level. Releases update the level silently.
module button_conditioner
    import stopwatch_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = ctr_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          press_r;
    logic [CW-1:0] cnt_r;
    logic          accept_s;

    // Acceptance fires on the last of DEBOUNCE_CYCLES differing cycles.
    always_comb begin
        accept_s = 1'b0;
        if ((sync2_r != level_r) && (cnt_r == CNT_LAST)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Two-flop synchronizer; resets to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
        end
    end

    // Stability counter, accepted level and press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {CW{1'b0}};
            level_r <= 1'b1;
            press_r <= 1'b0;
        end else begin
            press_r <= 1'b0;
            if (sync2_r == level_r) begin
                // Any return to the accepted level restarts the count.
                cnt_r <= {CW{1'b0}};
            end else if (accept_s) begin
                cnt_r   <= {CW{1'b0}};
                level_r <= sync2_r;
                press_r <= ~sync2_r;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/lap/reset sequencing for the stopwatch counter.
//   clk, rst_n   : 50 MHz system clock, asynchronous active-low reset
//   key_start_n  : raw KEY0 (active-low) - start/stop
//   key_lap_n    : raw KEY1 (active-low) - lap while counting, reset when paused
//   at_max       : counter saturated at 59:59
//   count_en     : one-cycle count tick (once per TICK_DIV cycles while counting)
//   count_clr    : one-cycle synchronous clear, issued on PAUSE -> IDLE
//   disp_freeze  : high while in LAP (display holds lap value)
//   state        : current FSM state
//   running      : high in RUN or LAP
// All outputs are registered. The prescaler advances on edges where the
// current state counts, so the edge that leaves RUN still advances it and
// the fraction held in PAUSE is exactly what remains on resume.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int TICK_DIV        = CLK_HZ,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_start_n,
    input  logic       key_lap_n,
    input  logic       at_max,
    output logic       count_en,
    output logic       count_clr,
    output logic       disp_freeze,
    output logic [1:0] state,
    output logic       running
);

    localparam int PW = ctr_width(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic          start_p_s;
    logic          lap_p_s;
    sw_state_e     state_r;
    sw_state_e     next_state_s;
    logic          clr_s;
    logic          counting_s;
    logic          wrap_s;
    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_next_s;
    logic          count_en_r;
    logic          count_clr_r;
    logic          disp_freeze_r;
    logic          running_r;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_start (
        .clk  (clk),
        .rst_n(rst_n),
        .key_n(key_start_n),
        .press(start_p_s)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_lap (
        .clk  (clk),
        .rst_n(rst_n),
        .key_n(key_lap_n),
        .press(lap_p_s)
    );

    // Next-state logic; start outranks everything, at_max outranks lap.
    always_comb begin
        next_state_s = state_r;
        clr_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_p_s) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (start_p_s || at_max) begin
                    next_state_s = PAUSE;
                end else if (lap_p_s) begin
                    next_state_s = LAP;
                end else begin
                    next_state_s = RUN;
                end
            end
            LAP: begin
                if (start_p_s || at_max) begin
                    next_state_s = PAUSE;
                end else if (lap_p_s) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = LAP;
                end
            end
            PAUSE: begin
                if (start_p_s) begin
                    // A saturated counter cannot resume.
                    if (at_max) begin
                        next_state_s = PAUSE;
                    end else begin
                        next_state_s = RUN;
                    end
                end else if (lap_p_s) begin
                    next_state_s = IDLE;
                    clr_s        = 1'b1;
                end else begin
                    next_state_s = PAUSE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Prescaler next value: count while RUN/LAP, hold in PAUSE, zero on clear.
    always_comb begin
        counting_s   = (state_r == RUN) || (state_r == LAP);
        wrap_s       = counting_s && (presc_r == PRESC_LAST);
        presc_next_s = presc_r;
        if (clr_s) begin
            presc_next_s = {PW{1'b0}};
        end else if (wrap_s) begin
            presc_next_s = {PW{1'b0}};
        end else if (counting_s) begin
            presc_next_s = presc_r + PW'(1);
        end else begin
            presc_next_s = presc_r;
        end
    end

    // State, prescaler and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            presc_r       <= {PW{1'b0}};
            count_en_r    <= 1'b0;
            count_clr_r   <= 1'b0;
            disp_freeze_r <= 1'b0;
            running_r     <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            presc_r       <= presc_next_s;
            // Tick is suppressed at saturation; clr_s only occurs in PAUSE,
            // where wrap_s is low, so the two pulses never coincide.
            count_en_r    <= wrap_s & ~at_max;
            count_clr_r   <= clr_s;
            disp_freeze_r <= (next_state_s == LAP);
            running_r     <= (next_state_s == RUN) || (next_state_s == LAP);
        end
    end

    assign count_en    = count_en_r;
    assign count_clr   = count_clr_r;
    assign disp_freeze = disp_freeze_r;
    assign state       = state_r;
    assign running     = running_r;

endmodule
